apb_master_bridge: RTL and testbench

- Synthesizable APB initiator: converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Returns read data and error status on a one-cycle response strobe.
- Sits between an internal request source (CPU-side logic or sequencer) and APB peripherals.
- The counterpart of the APB slave side in the APB VIP. Verified against the slave VIP interface on the same clk.

---
 rtl/apb_master_bridge_if.sv | 35 +++
 rtl/apb_master_bridge.sv | 128 ++++++++++++
 tb/tb_apb_master_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the peripheral/source side.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns valid/ready commands into SETUP/ACCESS transfers with a one-cycle response.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  apb_master_bridge_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_r;
  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic [DATA_WIDTH-1:0] pwdata_r;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  // Transfer sequencer: owns every output register of the bridge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      pwdata_r    <= {DATA_WIDTH{1'b0}};
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
      wait_cnt_r  <= {CNT_W{1'b0}};
`endif
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            pwrite_r    <= bus.cmd_write;
            paddr_r     <= bus.cmd_addr;
            pwdata_r    <= bus.cmd_wdata;
            cmd_ready_r <= 1'b0;
            psel_r      <= 1'b1;
            penable_r   <= 1'b0;
            state_r     <= ST_SETUP;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_SETUP: begin
          // pready is deliberately not looked at here; ACCESS always follows.
          penable_r <= 1'b1;
          state_r   <= ST_ACCESS;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
          wait_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.prdata;
            rsp_err_r   <= bus.pslverr;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
          end else if (wait_cnt_r == CNT_LAST) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
`else
          end else begin
            state_r <= ST_ACCESS;
`endif
          end
        end
        default: begin
          // Illegal encoding: drop the bus and recover to IDLE without a response.
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.psel      = psel_r;
  assign bus.penable   = penable_r;
  assign bus.pwrite    = pwrite_r;
  assign bus.paddr     = paddr_r;
  assign bus.pwdata    = pwdata_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; the APB slave side is driven cycle by cycle.
module tb_apb_master_bridge;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %0b want 1", bus.cmd_ready); else n_pass++;
    n_checks++; if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 5'b00000) $display("FAIL rst_ctrl: got %05b want 00000", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err}); else n_pass++;
    n_checks++; if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) $display("FAIL rst_data: got %h want 0", {bus.paddr, bus.pwdata, bus.rsp_rdata}); else n_pass++;
    rst = 1'b0;
    cyc();
    n_checks++; if ({bus.cmd_ready, bus.psel} !== 2'b10) $display("FAIL rst_release: got %02b want 10", {bus.cmd_ready, bus.psel}); else n_pass++;
  endtask

  task automatic test_zero_wait_write();
    bus.pready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_0001);
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL zw_ready_n: got %0b want 1", bus.cmd_ready); else n_pass++;
    cyc();
    bus.cmd_valid = 1'b0;
    n_checks++; if ({bus.psel, bus.penable, bus.cmd_ready, bus.pwrite} !== 4'b1001) $display("FAIL zw_setup: got %04b want 1001", {bus.psel, bus.penable, bus.cmd_ready, bus.pwrite}); else n_pass++;
    n_checks++; if (bus.paddr !== 32'h0000_0010 || bus.pwdata !== 32'hA5A5_0001) $display("FAIL zw_addr_data: got %h/%h want 00000010/a5a50001", bus.paddr, bus.pwdata); else n_pass++;
    cyc();
    n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) $display("FAIL zw_access: got %03b want 110", {bus.psel, bus.penable, bus.rsp_valid}); else n_pass++;
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready} !== 5'b10001) $display("FAIL zw_rsp: got %05b want 10001", {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready}); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL zw_rdata: got %h want 00000000", bus.rsp_rdata); else n_pass++;
    cyc();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.paddr !== 32'h0000_0010) $display("FAIL zw_after: got %0b/%h want 0/00000010", bus.rsp_valid, bus.paddr); else n_pass++;
  endtask

  task automatic test_wait_read();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h1111_1111;
    issue(1'b0, 32'h0000_0024, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    n_checks++; if ({bus.psel, bus.penable} !== 2'b10) $display("FAIL wr3_setup: got %02b want 10", {bus.psel, bus.penable}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        bus.pready  = 1'b1;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hDEAD_BEEF;
      end
      n_checks++; if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid} !== 4'b1100 || bus.paddr !== 32'h0000_0024) $display("FAIL wr3_hold%0d: got %04b/%h want 1100/00000024", i, {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}, bus.paddr); else n_pass++;
    end
    cyc();
    bus.pready = 1'b0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.psel} !== 3'b100) $display("FAIL wr3_rsp: got %03b want 100", {bus.rsp_valid, bus.rsp_err, bus.psel}); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL wr3_rdata: got %h want deadbeef", bus.rsp_rdata); else n_pass++;
    cyc();
  endtask

  task automatic test_slave_err();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h0BAD_0030;
    issue(1'b0, 32'h0000_0030, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b11 || bus.rsp_rdata !== 32'h0BAD_0030) $display("FAIL err_rsp: got %02b/%h want 11/0bad0030", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); else n_pass++;
    bus.pslverr = 1'b0;
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b01) $display("FAIL err_hold: got %02b want 01", {bus.rsp_valid, bus.rsp_err}); else n_pass++;
    issue(1'b1, 32'h0000_0034, 32'h5555_AAAA);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10 || bus.rsp_rdata !== 32'h0) $display("FAIL err_next: got %02b/%h want 10/00000000", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic exp_rsp;
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_rsp = (k > 0) ? 1'b1 : 1'b0;
      issue(1'b1, 32'h0000_0040 + 32'(4 * k), 32'hB0B0_0000 + 32'(k));
      n_checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== {1'b1, exp_rsp, 1'b0}) $display("FAIL b2b_gap%0d: got %03b want %03b", k, {bus.cmd_ready, bus.rsp_valid, bus.psel}, {1'b1, exp_rsp, 1'b0}); else n_pass++;
      cyc();
      n_checks++; if ({bus.psel, bus.cmd_ready} !== 2'b10 || bus.paddr !== 32'h0000_0040 + 32'(4 * k) || bus.pwdata !== 32'hB0B0_0000 + 32'(k)) $display("FAIL b2b_setup%0d: got %02b/%h/%h", k, {bus.psel, bus.cmd_ready}, bus.paddr, bus.pwdata); else n_pass++;
      cyc();
      n_checks++; if ({bus.penable, bus.rsp_valid} !== 2'b10) $display("FAIL b2b_access%0d: got %02b want 10", k, {bus.penable, bus.rsp_valid}); else n_pass++;
      cyc();
    end
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_last_rsp: got %0b want 1", bus.rsp_valid); else n_pass++;
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.psel, bus.cmd_ready} !== 3'b001) $display("FAIL b2b_idle: got %03b want 001", {bus.rsp_valid, bus.psel, bus.cmd_ready}); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    bus.pready = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001 || bus.paddr !== 32'h0) $display("FAIL mid_rst_async: got %04b/%h want 0001/00000000", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, bus.paddr); else n_pass++;
    cyc();
    rst = 1'b0;
    bus.pready = 1'b1;
    cyc();
    n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) $display("FAIL mid_rst_after: got %04b want 0001", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}); else n_pass++;
    bus.prdata = 32'h1234_5678;
    issue(1'b0, 32'h0000_0054, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678) $display("FAIL mid_rst_recover: got %0b/%h want 1/12345678", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
    cyc();
  endtask

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    bus.pready = 1'b0;
    bus.prdata = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_0060, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) $display("FAIL to_wait%0d: got %03b want 110", i, {bus.psel, bus.penable, bus.rsp_valid}); else n_pass++;
    end
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready} !== 5'b11001 || bus.rsp_rdata !== 32'h0) $display("FAIL to_abort: got %05b/%h want 11001/00000000", {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.cmd_ready}, bus.rsp_rdata); else n_pass++;
    cyc();
    n_checks++; if ({bus.rsp_valid, bus.psel} !== 2'b00) $display("FAIL to_idle: got %02b want 00", {bus.rsp_valid, bus.psel}); else n_pass++;
  endtask

  task automatic test_timeout_pready_wins();
    bus.pready = 1'b0;
    issue(1'b0, 32'h0000_0064, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 15) begin
        bus.pready = 1'b1;
        bus.prdata = 32'h0000_C0DE;
      end
    end
    cyc();
    bus.pready = 1'b0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10 || bus.rsp_rdata !== 32'h0000_C0DE) $display("FAIL to_race: got %02b/%h want 10/0000c0de", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); else n_pass++;
    cyc();
  endtask
`else
  task automatic test_no_timeout();
    bus.pready = 1'b0;
    bus.prdata = 32'hABCD_0070;
    issue(1'b0, 32'h0000_0070, 32'h0);
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) $display("FAIL nto_wait%0d: got %03b want 110", i, {bus.psel, bus.penable, bus.rsp_valid}); else n_pass++;
    end
    bus.pready = 1'b1;
    cyc();
    bus.pready = 1'b0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10 || bus.rsp_rdata !== 32'hABCD_0070) $display("FAIL nto_done: got %02b/%h want 10/abcd0070", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); else n_pass++;
    cyc();
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_err();
    test_back_to_back();
    test_reset_mid_access();
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    test_timeout();
    test_timeout_pready_wins();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
